alu: RTL and testbench



---
 rtl/alu_pkg.sv | 40 ++++
 rtl/alu_shifter.sv | 50 +++++
 rtl/alu.sv | 146 ++++++++++++++
 tb/tb_alu.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants and types for the execute-stage ALU.
// Optional flag output is enabled by defining ALU_FLAGS_EN.
package alu_pkg;

  localparam int ALU_WIDTH = 16;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_NOT = 4'd5,
    OP_SHL = 4'd6,
    OP_SHR = 4'd7,
    OP_SRA = 4'd8,
    OP_ROL = 4'd9,
    OP_ROR = 4'd10,
    OP_MUL = 4'd11,
    OP_INC = 4'd12,
    OP_DEC = 4'd13,
    OP_SLT = 4'd14,
    OP_NOR = 4'd15
  } op_e;

  typedef enum logic [2:0] {
    SH_SHL = 3'd0,
    SH_SHR = 3'd1,
    SH_SRA = 3'd2,
    SH_ROL = 3'd3,
    SH_ROR = 3'd4
  } shift_mode_e;

  // Bit positions inside the {N,Z,C,V} flag word
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_shifter.sv
// Combinational shift/rotate unit. Returns the shifted word and the last
// bit shifted out (0 for rotates and for a zero amount).
module alu_shifter
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  localparam int AW = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] a,
  input  logic [AW-1:0]    amount,
  input  shift_mode_e      mode,
  output logic [WIDTH-1:0] result,
  output logic             carry
);

  // One extra bit on the exit side of each shift catches the last bit out
  logic [WIDTH:0] shl_ext;
  logic [WIDTH:0] shr_ext;
  logic [WIDTH:0] sra_ext;

  // Select the shift flavour; rotates are built from two opposing shifts
  always_comb begin
    shl_ext = {1'b0, a} << amount;
    shr_ext = {a, 1'b0} >> amount;
    sra_ext = $signed({a, 1'b0}) >>> amount;
    result  = a;
    carry   = 1'b0;
    case (mode)
      SH_SHL: begin
        result = shl_ext[WIDTH-1:0];
        carry  = shl_ext[WIDTH];
      end
      SH_SHR: begin
        result = shr_ext[WIDTH:1];
        carry  = shr_ext[0];
      end
      SH_SRA: begin
        result = sra_ext[WIDTH:1];
        carry  = sra_ext[0];
      end
      SH_ROL: result = (a << amount) | (a >> (WIDTH - int'(amount)));
      SH_ROR: result = (a >> amount) | (a << (WIDTH - int'(amount)));
      default: begin
        result = a;
        carry  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu.sv
// Execute-stage ALU: 16 operations on A/B, result registered one cycle
// after sampling. Define ALU_FLAGS_EN to add the registered {N,Z,C,V} flags.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  localparam int AW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       sel,
  output logic [WIDTH-1:0] resault
`ifdef ALU_FLAGS_EN
  ,
  output logic [3:0]       flags
`endif
);

  op_e              op;
  shift_mode_e      sh_mode;
  logic [WIDTH-1:0] sh_result;
  logic [WIDTH-1:0] result_next;

  assign op = op_e'(sel);

  // Map shift/rotate opcodes onto the shifter's mode encoding
  always_comb begin
    sh_mode = SH_SHL;
    case (op)
      OP_SHR:  sh_mode = SH_SHR;
      OP_SRA:  sh_mode = SH_SRA;
      OP_ROL:  sh_mode = SH_ROL;
      OP_ROR:  sh_mode = SH_ROR;
      default: sh_mode = SH_SHL;
    endcase
  end

`ifdef ALU_FLAGS_EN
  logic sh_carry;
`else
  logic sh_carry_unused;
`endif

  alu_shifter #(.WIDTH(WIDTH)) u_shifter (
    .a      (A),
    .amount (B[AW-1:0]),
    .mode   (sh_mode),
    .result (sh_result),
`ifdef ALU_FLAGS_EN
    .carry  (sh_carry)
`else
    .carry  (sh_carry_unused)
`endif
  );

  // Opcode decode; all arithmetic wraps at WIDTH bits
  always_comb begin
    result_next = '0;
    case (op)
      OP_ADD: result_next = A + B;
      OP_SUB: result_next = A - B;
      OP_AND: result_next = A & B;
      OP_OR:  result_next = A | B;
      OP_XOR: result_next = A ^ B;
      OP_NOT: result_next = ~A;
      OP_SHL, OP_SHR, OP_SRA, OP_ROL, OP_ROR: result_next = sh_result;
      OP_MUL: result_next = A * B;
      OP_INC: result_next = A + 1'b1;
      OP_DEC: result_next = A - 1'b1;
      OP_SLT: result_next = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_NOR: result_next = ~(A | B);
      default: result_next = '0;
    endcase
  end

  // Result register; reset clears it with no dependence on clk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) resault <= '0;
    else        resault <= result_next;
  end

`ifdef ALU_FLAGS_EN
  localparam int MSB = WIDTH - 1;

  logic [WIDTH:0] add_ext;
  logic [WIDTH:0] sub_ext;
  logic [WIDTH:0] inc_ext;
  logic [WIDTH:0] dec_ext;
  logic           c_next;
  logic           v_next;
  logic [3:0]     flags_next;

  // The top bit of the subtract extensions is the unsigned borrow
  assign add_ext = {1'b0, A} + {1'b0, B};
  assign sub_ext = {1'b0, A} - {1'b0, B};
  assign inc_ext = {1'b0, A} + {{WIDTH{1'b0}}, 1'b1};
  assign dec_ext = {1'b0, A} - {{WIDTH{1'b0}}, 1'b1};

  // Carry/borrow and signed overflow for the operations that define them
  always_comb begin
    c_next = 1'b0;
    v_next = 1'b0;
    case (op)
      OP_ADD: begin
        c_next = add_ext[WIDTH];
        v_next = (A[MSB] == B[MSB]) && (add_ext[MSB] != A[MSB]);
      end
      OP_SUB: begin
        c_next = sub_ext[WIDTH];
        v_next = (A[MSB] != B[MSB]) && (sub_ext[MSB] != A[MSB]);
      end
      OP_INC: begin
        c_next = inc_ext[WIDTH];
        v_next = !A[MSB] && inc_ext[MSB];
      end
      OP_DEC: begin
        c_next = dec_ext[WIDTH];
        v_next = A[MSB] && !dec_ext[MSB];
      end
      OP_SHL, OP_SHR, OP_SRA: c_next = sh_carry;
      default: begin
        c_next = 1'b0;
        v_next = 1'b0;
      end
    endcase
  end

  // Assemble {N,Z,C,V} from the next result
  always_comb begin
    flags_next         = '0;
    flags_next[FLAG_N] = result_next[MSB];
    flags_next[FLAG_Z] = (result_next == '0);
    flags_next[FLAG_C] = c_next;
    flags_next[FLAG_V] = v_next;
  end

  // Flags share the result's latency and reset value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flags <= '0;
    else        flags <= flags_next;
  end
`endif

endmodule

// File: tb/tb_alu.sv
module tb_alu;

  logic        clk;
  logic        rst_n;
  logic [15:0] A;
  logic [15:0] B;
  logic [3:0]  sel;
  logic [15:0] resault;
`ifdef ALU_FLAGS_EN
  logic [3:0]  flags;
`endif

  int checks = 0;
  int errors = 0;

  alu dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .A       (A),
    .B       (B),
    .sel     (sel),
    .resault (resault)
`ifdef ALU_FLAGS_EN
    ,
    .flags   (flags)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic longint floor_div(input longint p, input longint q);
    longint r;
    r = p / q;
    if ((p % q) != 0 && p < 0) r = r - 1;
    return r;
  endfunction

  // Reference: each operation from its arithmetic definition on integers
  function automatic logic [15:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic [3:0] s, output logic [3:0] fl);
    longint ua, ub, sa, sb, x, d;
    int n;
    logic c, v;
    logic [15:0] r;
    ua = longint'(a);
    ub = longint'(b);
    sa = a[15] ? ua - 65536 : ua;
    sb = b[15] ? ub - 65536 : ub;
    n  = int'(b % 16);
    d  = 1;
    for (int i = 0; i < n; i++) d = d * 2;
    c = 1'b0;
    v = 1'b0;
    r = '0;
    case (s)
      4'd0: begin
        x = ua + ub; r = 16'(x % 65536); c = (x >= 65536);
        v = (sa + sb > 32767) || (sa + sb < -32768);
      end
      4'd1: begin
        x = ua - ub + 65536; r = 16'(x % 65536); c = (ua < ub);
        v = (sa - sb > 32767) || (sa - sb < -32768);
      end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = 16'(65535 - ua);
      4'd6: begin
        x = ua * d; r = 16'(x % 65536);
        c = (n > 0) && (((x / 65536) % 2) == 1);
      end
      4'd7: begin
        r = 16'(ua / d);
        c = (n > 0) && (((ua / (d / 2)) % 2) == 1);
      end
      4'd8: begin
        x = floor_div(sa, d); r = 16'((x + 65536) % 65536);
        c = (n > 0) && ((floor_div(sa, d / 2) & 1) == 1);
      end
      4'd9:  r = 16'(((ua * d) % 65536) + (ua / (65536 / d)));
      4'd10: r = 16'((ua / d) + ((ua * (65536 / d)) % 65536));
      4'd11: r = 16'((ua * ub) % 65536);
      4'd12: begin
        x = ua + 1; r = 16'(x % 65536); c = (x >= 65536); v = (sa + 1 > 32767);
      end
      4'd13: begin
        x = ua + 65535; r = 16'(x % 65536); c = (ua == 0); v = (sa - 1 < -32768);
      end
      4'd14: r = (sa < sb) ? 16'd1 : 16'd0;
      4'd15: r = 16'(65535 - (ua | ub));
      default: r = '0;
    endcase
    fl = {r[15], (r == 16'd0), c, v};
    return r;
  endfunction

  task automatic step(input logic [15:0] a, input logic [15:0] b, input logic [3:0] s);
    @(negedge clk);
    A = a;
    B = b;
    sel = s;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_flags(input string tag, input logic [3:0] exp);
`ifdef ALU_FLAGS_EN
    checks++;
    assert (flags === exp) else begin
      errors++;
      $error("FAIL %s flags got %b expected %b", tag, flags, exp);
    end
`else
    if (exp === 4'bxxxx) $display("unused %s", tag);
`endif
  endtask

  logic [15:0] ra, rb, exp_r;
  logic [3:0]  rs, exp_f;
  logic [15:0] edges [8];

  initial begin
    edges[0] = 16'h0000; edges[1] = 16'hFFFF; edges[2] = 16'h8000; edges[3] = 16'h7FFF;
    edges[4] = 16'h0001; edges[5] = 16'h000F; edges[6] = 16'h0010; edges[7] = 16'h8001;
    rst_n = 1'b0;
    A = 16'd10;
    B = 16'd3;
    sel = 4'd0;
    #1;
    check("reset_initial", resault, 16'h0000);
    check_flags("reset_initial", 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;

    // Nonzero value, then asynchronous reset between edges
    step(16'd10, 16'd3, 4'd0);
    check("add_10_3", resault, 16'h000D);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", resault, 16'h0000);
    check_flags("async_reset", 4'b0000);
    @(posedge clk);
    #1;
    check("reset_held", resault, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    A = 16'd10; B = 16'd3; sel = 4'd1;
    @(posedge clk);
    #1;
    check("first_sub", resault, 16'h0007);

    step(16'd10, 16'd3, 4'd3);  check("or",   resault, 16'h000B);
    step(16'd10, 16'd3, 4'd5);  check("not",  resault, 16'hFFF5);
    step(16'd10, 16'd3, 4'd7);  check("shr",  resault, 16'h0001);
    step(16'd10, 16'd3, 4'd9);  check("rol",  resault, 16'h0050);
    step(16'd10, 16'd3, 4'd10); check("ror",  resault, 16'h4001);
    step(16'd10, 16'd3, 4'd11); check("mul",  resault, 16'h001E);
    step(16'd10, 16'd3, 4'd13); check("dec",  resault, 16'h0009);
    step(16'd10, 16'd3, 4'd15); check("nor",  resault, 16'hFFF4);

    step(16'hFFFF, 16'h0001, 4'd0);  check("add_wrap", resault, 16'h0000);
    step(16'hFFFF, 16'h0000, 4'd12); check("inc_wrap", resault, 16'h0000);
    step(16'h0000, 16'h0000, 4'd13); check("dec_wrap", resault, 16'hFFFF);
    step(16'h00FF, 16'h0100, 4'd11); check("mul_wrap", resault, 16'hFF00);
    step(16'h8000, 16'd15, 4'd8);    check("sra_15",   resault, 16'hFFFF);
    step(16'h8001, 16'h0011, 4'd9);  check("rol_b_hi", resault, 16'h0003);
    step(16'h1234, 16'h0000, 4'd6);  check("shl_0",    resault, 16'h1234);
    step(16'h1234, 16'hFFF0, 4'd10); check("ror_0",    resault, 16'h1234);
    step(16'h8000, 16'h0001, 4'd14); check("slt_neg",  resault, 16'h0001);
    step(16'd5, 16'd5, 4'd14);       check("slt_eq",   resault, 16'h0000);

    step(16'h7FFF, 16'h0001, 4'd0);
    check("add_ovf", resault, 16'h8000);
    check_flags("add_ovf", 4'b1001);
    step(16'd3, 16'd3, 4'd1);
    check("sub_zero", resault, 16'h0000);
    check_flags("sub_zero", 4'b0100);
    step(16'h0000, 16'h0000, 4'd13);
    check_flags("dec_borrow", 4'b1010);
    step(16'h8000, 16'h0001, 4'd6);
    check_flags("shl_carry", 4'b0110);

    // Randomized vectors against the arithmetic reference
    for (int i = 0; i < 400; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rs = 4'($urandom);
      if ((i % 4) == 1) ra = edges[$urandom_range(0, 7)];
      if ((i % 4) == 2) rb = edges[$urandom_range(0, 7)];
      exp_r = model(ra, rb, rs, exp_f);
      step(ra, rb, rs);
      check($sformatf("rand%0d_sel%0d", i, rs), resault, exp_r);
      check_flags($sformatf("rand%0d_sel%0d", i, rs), exp_f);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
